serial_code_loader: RTL and testbench

Upstream feeder for the 16-bit Gray/binary code converter. It deserialises an MSB-first serial bitstream into a parallel word and latches the per-word conversion mode. It presents the word as P and the mode as k, held stable under a valid/ready handshake. It also produces a running XOR (word parity) as a cross-check against the converter's Gray-to-binary LSB.

---
 rtl/serial_code_loader.sv | 112 +++++++++++
 tb/tb_serial_code_loader.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_code_loader.sv
// Deserialises an MSB-first bitstream into a WIDTH-bit word plus conversion mode and running parity.
// The word appears WIDTH cycles after the start edge and is held under valid/ready until accepted.
module serial_code_loader #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode_in,
  input  logic             sdata,
  output logic [WIDTH-1:0] P,
  output logic             k,
  output logic             valid,
  input  logic             ready,
  output logic             busy,
  output logic             parity
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             xor_acc;
  logic             mode_hold;
  logic             load_frame;
  logic             last_bit;
  logic             release_word;

  always_comb begin
    state_nxt    = state;
    load_frame   = 1'b0;
    last_bit     = 1'b0;
    release_word = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_frame = 1'b1;
          state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == LAST_BIT) begin
          last_bit  = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // start only counts once the held word is accepted, so no overrun
        if (ready) begin
          release_word = 1'b1;
          if (start) begin
            load_frame = 1'b1;
            state_nxt  = SHIFT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      cnt       <= '0;
      xor_acc   <= 1'b0;
      mode_hold <= 1'b0;
      P         <= '0;
      k         <= 1'b0;
      parity    <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (release_word) begin
        valid <= 1'b0;
      end
      if (load_frame) begin
        mode_hold <= mode_in;
        cnt       <= '0;
        xor_acc   <= 1'b0;
        busy      <= 1'b1;
      end
      if (state == SHIFT) begin
        sreg    <= {sreg[WIDTH-2:0], sdata};
        xor_acc <= xor_acc ^ sdata;
        if (last_bit) begin
          // P/k/parity only move here, so the converter sees no intermediate words
          P      <= {sreg[WIDTH-2:0], sdata};
          k      <= mode_hold;
          parity <= xor_acc ^ sdata;
          valid  <= 1'b1;
          busy   <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_code_loader.sv
// Scoreboard bench for serial_code_loader: frames push expected words, a negedge monitor pops and compares.
module tb_serial_code_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mode_in = 1'b0;
  logic        sdata = 1'b0;
  logic        ready = 1'b1;
  logic [15:0] P;
  logic        k;
  logic        valid;
  logic        busy;
  logic        parity;

  serial_code_loader #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode_in(mode_in),
    .sdata  (sdata),
    .P      (P),
    .k      (k),
    .valid  (valid),
    .ready  (ready),
    .busy   (busy),
    .parity (parity)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] p;
    logic        k;
    logic        par;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic        rst_q = 1'b1;
  logic        valid_prev = 1'b0;
  logic [15:0] hold_p = '0;
  logic        hold_k = 1'b0;
  logic        hold_par = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference 16-bit converter: k=0 binary->Gray, k=1 Gray->binary.
  function automatic logic [15:0] conv(input logic [15:0] v, input logic mode);
    logic [15:0] r;
    if (!mode) begin
      r = v ^ (v >> 1);
    end else begin
      r[15] = v[15];
      for (int i = 14; i >= 0; i--) r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    if (rst_q) begin
      check("rst_P", P, 0);
      check("rst_k", k, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_parity", parity, 0);
      hold_p   = '0;
      hold_k   = 1'b0;
      hold_par = 1'b0;
    end else begin
      check("valid_busy_excl", valid & busy, 0);
      if (valid && !valid_prev) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          me = sb.pop_front();
          check("word_P", P, me.p);
          check("word_k", k, me.k);
          check("word_parity", parity, me.par);
          check("valid_latency", cyc, me.cyc);
          hold_p   = me.p;
          hold_k   = me.k;
          hold_par = me.par;
        end
      end else begin
        check("P_stable", P, hold_p);
        check("k_stable", k, hold_k);
        check("parity_stable", parity, hold_par);
      end
    end
    valid_prev = valid;
  end

  // Drives one frame; pulse_at >= 0 raises start (with inverted mode) on that bit.
  task automatic frame(input logic [15:0] w, input logic m, input int pulse_at);
    exp_t e;
    start   = 1'b1;
    mode_in = m;
    @(posedge clk); #1;
    start = 1'b0;
    check("frame_busy", busy, 1);
    check("frame_no_valid", valid, 0);
    e.p   = w;
    e.k   = m;
    e.par = ^w;
    e.cyc = cyc + 16;
    sb.push_back(e);
    for (int i = 15; i >= 0; i--) begin
      sdata = w[i];
      if (15 - i == pulse_at) begin
        start   = 1'b1;
        mode_in = ~m;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    sdata = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [15:0] q;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: basic frame, accepted immediately, then IDLE
    ready = 1'b1;
    frame(16'hB5C3, 1'b0, -1);
    check("t1_valid", valid, 1);
    @(posedge clk); #1;
    check("t1_valid_drop", valid, 0);
    check("t1_idle_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;

    // 2: backpressure for 5 cycles
    ready = 1'b0;
    frame(16'hFFFF, 1'b1, -1);
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t2_hold_valid", valid, 1);
      check("t2_hold_busy", busy, 0);
    end
    start = 1'b0;
    ready = 1'b1;
    @(posedge clk); #1;
    check("t2_valid_drop", valid, 0);
    @(posedge clk); #1;

    // 3: back-to-back frames via start in the HOLD cycle
    frame(16'h1234, 1'b0, -1);
    frame(16'h8001, 1'b1, -1);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // 4: start pulse mid-frame is ignored
    frame(16'h00FF, 1'b1, 3);
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // 5: reset mid-frame, then a clean frame
    start   = 1'b1;
    mode_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 15; i >= 9; i--) begin
      sdata = i[0] ? 1'b1 : 1'b0;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_busy_after_rst", busy, 0);
    check("t5_P_after_rst", P, 0);
    @(posedge clk); #1;
    frame(16'h5555, 1'b0, -1);
    @(posedge clk); #1;

    // 6: feed the reference converter from P/k
    frame(16'h8000, 1'b0, -1);
    check("t6_conv_b2g", conv(P, k), 16'hC000);
    frame(16'h8000, 1'b1, -1);
    q = conv(P, k);
    check("t6_conv_g2b", q, 16'hFFFF);
    check("t6_parity_q0", parity, q[0]);
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
